// File: rtl/tspp_types_pkg.sv
// ============================================================================
// Module  : tspp_types_pkg
// Brief   : Shared types and constants for the pipeline hazard controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package tspp_types_pkg;

    localparam int MAX_STAGES = 8;
    localparam int HOLD_CNT_W = 4;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } hazard_state_t;

    // Widest stage vector; instances truncate to their own NUM_STAGES.
    typedef logic [MAX_STAGES-1:0] stage_vec_t;

    function automatic stage_vec_t low_mask(input int n);
        stage_vec_t m;
        m = '0;
        for (int i = 0; i < MAX_STAGES; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
// ============================================================================
// Module  : pipeline_hazard_ctrl_if
// Brief   : Execute/fetch/pipeline-register hazard bundle; perf counters
//           present only when PIPE_HAZARD_PERF_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_hazard_ctrl_if #(
    parameter int NUM_STAGES = 2,
    parameter int ADDR_W     = 32
`ifdef PIPE_HAZARD_PERF_EN
    ,
    parameter int CNT_W      = 32
`endif
);
    logic                  dwait;
    logic                  iwait;
    logic                  branch_mispredict;
    logic [ADDR_W-1:0]     branch_jump_addr;
    logic                  fetch_redirect_ready;
    logic                  fetch_redirect_valid;
    logic [ADDR_W-1:0]     fetch_redirect_addr;
    logic [NUM_STAGES-1:0] stall;
    logic [NUM_STAGES-1:0] flush;
`ifdef PIPE_HAZARD_PERF_EN
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_events;
`endif

    modport master (
        input  dwait, iwait, branch_mispredict, branch_jump_addr, fetch_redirect_ready,
        output fetch_redirect_valid, fetch_redirect_addr, stall, flush
`ifdef PIPE_HAZARD_PERF_EN
        ,
        output stall_cycles, flush_events
`endif
    );

    modport slave (
        output dwait, iwait, branch_mispredict, branch_jump_addr, fetch_redirect_ready,
        input  fetch_redirect_valid, fetch_redirect_addr, stall, flush
`ifdef PIPE_HAZARD_PERF_EN
        ,
        input  stall_cycles, flush_events
`endif
    );

endinterface

`default_nettype wire

// File: rtl/pipe_hazard_perf_cnt.sv
// ============================================================================
// Module  : pipe_hazard_perf_cnt
// Brief   : Saturating event counter used by the hazard controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Brief   : Per-stage stall/flush generation and fetch redirect ownership for
//           an N-stage pipeline. Optional perf counters: PIPE_HAZARD_PERF_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
    import tspp_types_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int EX_STAGE   = 1,
    parameter int ADDR_W     = 32,
    parameter int FLUSH_HOLD = 0
`ifdef PIPE_HAZARD_PERF_EN
    ,
    parameter int CNT_W      = 32
`endif
) (
    input  logic                   CLK,
    input  logic                   nRST,
    pipeline_hazard_ctrl_if.master hz
);

    localparam logic [NUM_STAGES-1:0] c_LE_EX = NUM_STAGES'(low_mask(EX_STAGE + 1));
    localparam logic [NUM_STAGES-1:0] c_LT_EX = NUM_STAGES'(low_mask(EX_STAGE));
    localparam logic [NUM_STAGES-1:0] c_GT_EX = ~c_LE_EX;
    localparam logic [NUM_STAGES-1:0] c_S0    = NUM_STAGES'(1);
    localparam logic [NUM_STAGES-1:0] c_S1    = NUM_STAGES'(2);
    localparam logic [HOLD_CNT_W-1:0] c_HOLD  = HOLD_CNT_W'(FLUSH_HOLD);

    hazard_state_t         state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [HOLD_CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_STAGES-1:0] w_stall;
    logic [NUM_STAGES-1:0] w_flush;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        w_stall = '0;
        w_flush = '0;
        case (state_q)
            RUN: begin
                // dwait outranks a mispredict; execute keeps the mispredict up until dwait drops.
                if (hz.dwait) begin
                    w_stall = c_LE_EX;
                    w_flush = c_GT_EX;
                end else if (hz.branch_mispredict) begin
                    w_flush = c_LT_EX;
                    addr_d  = hz.branch_jump_addr;
                    state_d = REDIRECT;
                end else if (hz.iwait) begin
                    w_stall = c_S0;
                    w_flush = c_S1;
                end
            end
            REDIRECT: begin
                w_stall = c_S0;
                w_flush = c_LE_EX & ~c_S0;
                if (hz.fetch_redirect_ready) begin
                    if (FLUSH_HOLD > 0) begin
                        state_d = DRAIN;
                        cnt_d   = c_HOLD;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            DRAIN: begin
                w_flush = c_LE_EX;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == HOLD_CNT_W'(1)) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign hz.stall                = w_stall;
    assign hz.flush                = w_flush;
    assign hz.fetch_redirect_valid = (state_q == REDIRECT);
    assign hz.fetch_redirect_addr  = addr_q;

`ifdef PIPE_HAZARD_PERF_EN
    pipe_hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc_i (|w_stall),
        .cnt_o (hz.stall_cycles)
    );

    pipe_hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc_i ((state_q == RUN) && (state_d == REDIRECT)),
        .cnt_o (hz.flush_events)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module  : tb_pipeline_hazard_ctrl
// Brief   : Two controllers (FLUSH_HOLD 0 and 2) on shared stimulus, checked
//           against a rule-level model. Perf checks with PIPE_HAZARD_PERF_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

    localparam int NS = 3;
    localparam int EX = 1;
    localparam int AW = 32;
    localparam int CW = 4;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

`ifdef PIPE_HAZARD_PERF_EN
    pipeline_hazard_ctrl_if #(.NUM_STAGES(NS), .ADDR_W(AW), .CNT_W(CW)) if_a(), if_b();
`else
    pipeline_hazard_ctrl_if #(.NUM_STAGES(NS), .ADDR_W(AW)) if_a(), if_b();
`endif

    pipeline_hazard_ctrl #(.NUM_STAGES(NS), .EX_STAGE(EX), .ADDR_W(AW), .FLUSH_HOLD(0)
`ifdef PIPE_HAZARD_PERF_EN
        , .CNT_W(CW)
`endif
    ) u_dut_a (.CLK(CLK), .nRST(nRST), .hz(if_a));

    pipeline_hazard_ctrl #(.NUM_STAGES(NS), .EX_STAGE(EX), .ADDR_W(AW), .FLUSH_HOLD(2)
`ifdef PIPE_HAZARD_PERF_EN
        , .CNT_W(CW)
`endif
    ) u_dut_b (.CLK(CLK), .nRST(nRST), .hz(if_b));

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a redirect is either pending or the drain window has cycles left; otherwise running.
    int          m_pend  [2];
    int          m_drain [2];
    logic [31:0] m_addr  [2];
    int          m_scnt  [2];
    int          m_fcnt  [2];

    logic [NS-1:0] obs_st [2];
    logic [NS-1:0] obs_fl [2];
    logic          obs_v  [2];
    logic [31:0]   obs_ad [2];
    logic [CW-1:0] obs_sc [2];
    logic [CW-1:0] obs_fe [2];

    function automatic int hold_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic bit in_run(input int d);
        return (m_pend[d] == 0) && (m_drain[d] == 0);
    endfunction

    function automatic void reset_model();
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = 0; m_drain[d] = 0; m_addr[d] = '0; m_scnt[d] = 0; m_fcnt[d] = 0;
        end
    endfunction

    function automatic void model_out(input int d, input logic dw, iw, bm,
                                      output logic [NS-1:0] st, output logic [NS-1:0] fl);
        st = '0;
        fl = '0;
        for (int k = 0; k < NS; k++) begin
            if (in_run(d)) begin
                if (dw) begin
                    st[k] = (k <= EX);
                    fl[k] = (k > EX);
                end else if (bm) begin
                    fl[k] = (k < EX);
                end else if (iw) begin
                    st[k] = (k == 0);
                    fl[k] = (k == 1);
                end
            end else if (m_pend[d] != 0) begin
                st[k] = (k == 0);
                fl[k] = (k >= 1) && (k <= EX);
            end else begin
                fl[k] = (k <= EX);
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic dw, iw, bm, input logic [31:0] ja, input logic rdy);
        if_a.dwait = dw; if_a.iwait = iw; if_a.branch_mispredict = bm;
        if_a.branch_jump_addr = ja; if_a.fetch_redirect_ready = rdy;
        if_b.dwait = dw; if_b.iwait = iw; if_b.branch_mispredict = bm;
        if_b.branch_jump_addr = ja; if_b.fetch_redirect_ready = rdy;
    endtask

    task automatic sample();
        obs_st[0] = if_a.stall; obs_fl[0] = if_a.flush;
        obs_v[0]  = if_a.fetch_redirect_valid; obs_ad[0] = if_a.fetch_redirect_addr;
        obs_st[1] = if_b.stall; obs_fl[1] = if_b.flush;
        obs_v[1]  = if_b.fetch_redirect_valid; obs_ad[1] = if_b.fetch_redirect_addr;
`ifdef PIPE_HAZARD_PERF_EN
        obs_sc[0] = if_a.stall_cycles; obs_fe[0] = if_a.flush_events;
        obs_sc[1] = if_b.stall_cycles; obs_fe[1] = if_b.flush_events;
`else
        obs_sc[0] = '0; obs_fe[0] = '0; obs_sc[1] = '0; obs_fe[1] = '0;
`endif
    endtask

    task automatic check_idle_reset(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_valid%0d", tag, d), obs_v[d], 1'b0);
            chk($sformatf("%s_addr%0d", tag, d), obs_ad[d], 32'h0);
            chk($sformatf("%s_stall%0d", tag, d), obs_st[d], 3'b000);
            chk($sformatf("%s_flush%0d", tag, d), obs_fl[d], 3'b000);
`ifdef PIPE_HAZARD_PERF_EN
            chk($sformatf("%s_scnt%0d", tag, d), obs_sc[d], 4'h0);
            chk($sformatf("%s_fcnt%0d", tag, d), obs_fe[d], 4'h0);
`endif
        end
    endtask

    // One clock: drive at negedge, compare mid-low-phase, advance the model at posedge.
    task automatic cycle(input logic dw, iw, bm, input logic [31:0] ja, input logic rdy);
        logic [NS-1:0] est, efl;
        @(negedge CLK);
        drive(dw, iw, bm, ja, rdy);
        #1;
        sample();
        for (int d = 0; d < 2; d++) begin
            model_out(d, dw, iw, bm, est, efl);
            chk($sformatf("stall%0d", d), obs_st[d], est);
            chk($sformatf("flush%0d", d), obs_fl[d], efl);
            chk($sformatf("valid%0d", d), obs_v[d], m_pend[d] != 0);
            chk($sformatf("addr%0d", d), obs_ad[d], m_addr[d]);
            chk($sformatf("stall_flush_excl%0d", d), obs_st[d] & obs_fl[d], 3'b000);
`ifdef PIPE_HAZARD_PERF_EN
            chk($sformatf("stall_cycles%0d", d), obs_sc[d], m_scnt[d]);
            chk($sformatf("flush_events%0d", d), obs_fe[d], m_fcnt[d]);
`endif
        end
        if (dw) chk("dwait_only_in_run", obs_v[0] | obs_v[1], 1'b0);
        @(posedge CLK);
        for (int d = 0; d < 2; d++) begin
            model_out(d, dw, iw, bm, est, efl);
            if (|est && m_scnt[d] < (1 << CW) - 1) m_scnt[d]++;
            if (in_run(d)) begin
                if (!dw && bm) begin
                    m_pend[d] = 1;
                    m_addr[d] = ja;
                    if (m_fcnt[d] < (1 << CW) - 1) m_fcnt[d]++;
                end
            end else if (m_pend[d] != 0) begin
                if (rdy) begin
                    m_pend[d]  = 0;
                    m_drain[d] = hold_of(d);
                end
            end else begin
                m_drain[d]--;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        dw, iw, bm, rdy, hold_bm;
        logic [31:0] ja, held_addr;

        drive(0, 0, 0, 32'h0, 0);
        reset_model();
        #12;
        sample();
        check_idle_reset("rst");
        @(negedge CLK);
        nRST = 1'b1;

        // dwait for three cycles, then quiet
        repeat (3) begin
            cycle(1, 0, 0, 32'h0, 0);
            chk("tp_dwait_stall", obs_st[0], 3'b011);
            chk("tp_dwait_flush", obs_fl[0], 3'b100);
        end
        cycle(0, 0, 0, 32'h0, 1);
        chk("tp_dwait_after_stall", obs_st[0], 3'b000);
        chk("tp_dwait_after_flush", obs_fl[0], 3'b000);

        // mispredict, fetch holds ready low for two cycles
        cycle(0, 0, 1, 32'h0000_0200, 0);
        chk("tp_br_capture_flush", obs_fl[0], 3'b001);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 32'h0, (i == 2));
            chk("tp_br_valid", obs_v[0], 1'b1);
            chk("tp_br_addr", obs_ad[0], 32'h200);
            chk("tp_br_stall0", obs_st[0][0], 1'b1);
        end
        cycle(0, 0, 0, 32'h0, 0);
        chk("tp_br_valid_fell", obs_v[0], 1'b0);
        chk("tp_br_drain_b", obs_fl[1], 3'b011);
        cycle(0, 0, 0, 32'h0, 0);
        chk("tp_br_drain_b2", obs_fl[1], 3'b011);
        cycle(0, 0, 0, 32'h0, 0);
        chk("tp_br_drain_done_b", obs_fl[1], 3'b000);

        // dwait masks a held mispredict until it falls
        repeat (2) begin
            cycle(1, 0, 1, 32'h0000_ABC0, 0);
            chk("tp_dw_br_flush", obs_fl[0], 3'b100);
            chk("tp_dw_br_novalid", obs_v[0], 1'b0);
        end
        cycle(0, 0, 1, 32'h0000_ABC0, 1);
        chk("tp_dw_br_capture", obs_fl[0], 3'b001);
        cycle(0, 0, 0, 32'h0, 1);
        chk("tp_dw_br_valid", obs_v[0], 1'b1);
        chk("tp_dw_br_addr", obs_ad[0], 32'h0000_ABC0);

        // FLUSH_HOLD=2 instance: exactly two drain cycles after immediate accept
        for (int i = 0; i < 2; i++) begin
            cycle(0, 0, 0, 32'h0, 0);
            chk("tp_hold_flush", obs_fl[1], 3'b011);
            chk("tp_hold_stall", obs_st[1], 3'b000);
        end
        cycle(0, 0, 0, 32'h0, 0);
        chk("tp_hold_run", obs_fl[1], 3'b000);

        // asynchronous reset while a redirect is pending
        cycle(0, 0, 1, 32'h0000_1234, 0);
        cycle(0, 0, 0, 32'h0, 0);
        chk("tp_rst_pre_valid", obs_v[0], 1'b1);
        #2;
        drive(0, 0, 0, 32'h0, 0);
        nRST = 1'b0;
        #1;
        sample();
        check_idle_reset("tp_rst_mid");
        reset_model();
        @(negedge CLK);
        nRST = 1'b1;
        cycle(0, 1, 0, 32'h0, 0);
        chk("tp_restart_stall", obs_st[0], 3'b001);
        chk("tp_restart_flush", obs_fl[0], 3'b010);

        // long dwait run saturates the 4-bit stall counter
        repeat (20) cycle(1, 0, 0, 32'h0, 0);
        cycle(0, 0, 0, 32'h0, 0);
`ifdef PIPE_HAZARD_PERF_EN
        chk("tp_perf_sat", obs_sc[0], 4'hF);
`endif

        // randomized traffic
        hold_bm   = 1'b0;
        held_addr = '0;
        for (int i = 0; i < 400; i++) begin
            dw  = in_run(0) && in_run(1) && ($urandom_range(0, 3) == 0);
            iw  = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 1) == 1);
            if (hold_bm) begin
                bm = 1'b1;
                ja = held_addr;
            end else begin
                bm = ($urandom_range(0, 4) == 0);
                ja = $urandom;
            end
            hold_bm   = dw && bm;
            held_addr = ja;
            cycle(dw, iw, bm, ja, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
